// File: rtl/lzrw1_copy_engine.sv
// lzrw1_copy_engine
//   Decompressor back end. Expands decoded LZRW1 tokens (literal or copy) into
//   a byte stream. It is the only reader and writer of the history buffer:
//   every emitted byte is written back at wr_ptr, and copy bytes are read from
//   wr_ptr - offset.
//
// Ports
//   clock, reset                 system clock, synchronous active-low reset
//   tok_valid/tok_ready          token handshake (ready only when idle)
//   tok_is_copy                  1 = copy token, 0 = literal token
//   tok_literal                  literal byte
//   tok_offset, tok_length       copy distance back and copy length
//   out_valid/out_ready/out_data output byte stream
//   hb_wr_en/hb_wr_addr/hb_data_in  history write port
//   hb_rd_addr/hb_data_out       history read port (combinational read)
//   err_offset                   sticky flag: illegal copy token seen
module lzrw1_copy_engine #(
  parameter int HISTORY_SIZE = 4096,
  parameter int ENTRY_WIDTH  = 8,
  parameter int LEN_WIDTH    = 5,
  localparam int ADDR_WIDTH  = $clog2(HISTORY_SIZE)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tok_valid,
  output logic                   tok_ready,
  input  logic                   tok_is_copy,
  input  logic [ENTRY_WIDTH-1:0] tok_literal,
  input  logic [ADDR_WIDTH-1:0]  tok_offset,
  input  logic [LEN_WIDTH-1:0]   tok_length,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ENTRY_WIDTH-1:0] out_data,
  output logic                   hb_wr_en,
  output logic [ADDR_WIDTH-1:0]  hb_wr_addr,
  output logic [ENTRY_WIDTH-1:0] hb_data_in,
  output logic [ADDR_WIDTH-1:0]  hb_rd_addr,
  input  logic [ENTRY_WIDTH-1:0] hb_data_out,
  output logic                   err_offset
);

  typedef enum logic [1:0] {IDLE, LIT, COPY} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  valid_cnt;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [ENTRY_WIDTH-1:0] lit_reg;
  logic [ADDR_WIDTH-1:0]  off_reg;
  logic                   accept;
  logic                   tok_bad;
  logic                   hs;

  // Count of bytes ever written, capped once the whole history is valid.
  function automatic logic [ADDR_WIDTH-1:0] sat_inc(input logic [ADDR_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    tok_ready  = (state == IDLE);
    accept     = tok_valid && tok_ready;
    // A copy may not reach further back than the bytes actually written.
    tok_bad    = tok_is_copy &&
                 ((tok_offset == '0) || (tok_length == '0) || (tok_offset > valid_cnt));
    out_valid  = reset && ((state == LIT) || (state == COPY));
    out_data   = (state == COPY) ? hb_data_out : lit_reg;
    // Power-of-two history: the natural wrap of the subtraction is the modulo.
    hb_rd_addr = wr_ptr - off_reg;
    hs         = out_valid && out_ready;
    hb_wr_en   = hs;
    hb_wr_addr = wr_ptr;
    hb_data_in = out_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!tok_is_copy)  state_nxt = LIT;
          else if (!tok_bad) state_nxt = COPY;
        end
      end
      LIT:  if (hs) state_nxt = IDLE;
      COPY: if (hs && (remaining == LEN_WIDTH'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      valid_cnt  <= '0;
      remaining  <= '0;
      err_offset <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && tok_bad) err_offset <= 1'b1;
      if (accept && tok_is_copy && !tok_bad) remaining <= tok_length;
      else if (hs && (state == COPY))        remaining <= remaining - 1'b1;
      if (hs) begin
        wr_ptr    <= wr_ptr + 1'b1;
        valid_cnt <= sat_inc(valid_cnt);
      end
    end
  end

  // Token data registers
  always_ff @(posedge clock) begin
    if (accept) begin
      lit_reg <= tok_literal;
      off_reg <= tok_offset;
    end
  end

endmodule

// File: tb/tb_lzrw1_copy_engine.sv
module tb_lzrw1_copy_engine;
  localparam int HS = 4096;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic          tok_is_copy = 1'b0;
  logic [7:0]    tok_literal = '0;
  logic [AW-1:0] tok_offset = '0;
  logic [4:0]    tok_length = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          hb_wr_en;
  logic [AW-1:0] hb_wr_addr;
  logic [7:0]    hb_data_in;
  logic [AW-1:0] hb_rd_addr;
  logic [7:0]    hb_data_out;
  logic          err_offset;

  always #5 clock = ~clock;

  lzrw1_copy_engine dut (
    .clock(clock), .reset(reset),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_copy(tok_is_copy),
    .tok_literal(tok_literal), .tok_offset(tok_offset), .tok_length(tok_length),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hb_wr_en(hb_wr_en), .hb_wr_addr(hb_wr_addr), .hb_data_in(hb_data_in),
    .hb_rd_addr(hb_rd_addr), .hb_data_out(hb_data_out), .err_offset(err_offset)
  );

  // History buffer: combinational read, synchronous write
  logic [7:0] hmem [HS];
  assign hb_data_out = hmem[hb_rd_addr];
  always @(posedge clock) if (hb_wr_en) hmem[hb_wr_addr] <= hb_data_in;

  // Golden byte-serial model and scoreboard
  typedef struct { logic [7:0] data; logic [AW-1:0] addr; } exp_t;
  exp_t       sbq[$];
  logic [7:0] gmem [HS];
  int         gptr, gcnt;
  bit         gerr;
  int         checks = 0, failures = 0;
  bit         ready_rand = 1'b0;

  typedef struct {
    bit         rst_before;
    bit         is_copy;
    logic [7:0] lit;
    int         off;
    int         len;
    bit         exp_err;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic golden_clear();
    gptr = 0; gcnt = 0; gerr = 1'b0;
    sbq.delete();
  endtask

  task automatic gold_push(input logic [7:0] b);
    exp_t e;
    e.data = b; e.addr = gptr[AW-1:0];
    sbq.push_back(e);
    gmem[gptr] = b;
    gptr = (gptr + 1) % HS;
    if (gcnt < HS - 1) gcnt++;
  endtask

  task automatic gold_token(input bit c, input logic [7:0] l, input int off, input int len,
                            output bit bad);
    bad = c && (off == 0 || len == 0 || off > gcnt);
    if (bad) gerr = 1'b1;
    else if (!c) gold_push(l);
    else for (int i = 0; i < len; i++) gold_push(gmem[(gptr - off) & (HS - 1)]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send_tok(input bit c, input logic [7:0] l, input int off, input int len);
    bit bad;
    int w;
    tok_valid = 1'b1; tok_is_copy = c; tok_literal = l;
    tok_offset = off[AW-1:0]; tok_length = len[4:0];
    w = 0;
    @(negedge clock);
    while (!tok_ready && w < 1000) begin @(negedge clock); w++; end
    if (!tok_ready) begin
      check("tok_ready_timeout", int'(tok_ready), 1);
      tok_valid = 1'b0;
      @(posedge clock); #1;
      return;
    end
    gold_token(c, l, off, len, bad);
    @(posedge clock); #1;
    tok_valid = 1'b0;
    check("out_valid_after_accept", int'(out_valid), int'(!bad));
    check("err_offset", int'(err_offset), int'(gerr));
    if (bad) check("tok_ready_after_err", int'(tok_ready), 1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sbq.size() != 0 || out_valid) && w < 5000) begin @(negedge clock); w++; end
    check("drain_queue_empty", sbq.size(), 0);
    check("drain_out_valid", int'(out_valid), 0);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    golden_clear();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Output monitor: a handshake at the next posedge is decided by what is
  // stable at the negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("out_valid_in_reset", int'(out_valid), 0);
        check("hb_wr_en_in_reset", int'(hb_wr_en), 0);
      end else if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_byte actual=%0h required=none", out_data);
        end else begin
          e = sbq.pop_front();
          check("out_data", int'(out_data), int'(e.data));
          check("hb_wr_en_on_hs", int'(hb_wr_en), 1);
          check("hb_wr_addr", int'(hb_wr_addr), int'(e.addr));
          check("hb_data_in", int'(hb_data_in), int'(e.data));
        end
      end else begin
        check("hb_wr_en_no_hs", int'(hb_wr_en), 0);
      end
    end
  end

  // out_ready changes only just after a rising edge
  initial begin
    forever begin
      @(posedge clock); #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < HS; i++) begin hmem[i] = 8'h00; gmem[i] = 8'h00; end
    tbl[0]  = '{1'b1, 1'b0, 8'h41, 0,   0,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 1,   4,  1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h61, 0,   0,  1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h62, 0,   0,  1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h63, 0,   0,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 3,   6,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 0,   2,  1'b1};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 5,   0,  1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 100, 3,  1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 14,  18, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'h00, 1,   3,  1'b1};

    do_reset();
    check("reset_tok_ready", int'(tok_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_wr_addr", int'(hb_wr_addr), 0);
    check("reset_err", int'(err_offset), 0);

    // Table: literal/overlapping copies and illegal copy tokens
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_before) begin drain(); do_reset(); end
      send_tok(tbl[i].is_copy, tbl[i].lit, tbl[i].off, tbl[i].len);
      check($sformatf("tbl_err_%0d", i), int'(err_offset), int'(tbl[i].exp_err));
    end
    drain();
    // Erroring token right after reset leaves the engine idle with no output
    check("err_no_output_wr_addr", int'(hb_wr_addr), 0);

    // Reset while a copy still has 7 bytes to go
    do_reset();
    send_tok(1'b1, 8'h00, 3, 3);
    send_tok(1'b0, 8'h9c, 0, 0);
    drain();
    send_tok(1'b1, 8'h00, 1, 10);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    golden_clear();
    @(posedge clock); #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_wr_ptr", int'(hb_wr_addr), 0);
    check("midrst_idle", int'(tok_ready), 1);
    check("midrst_err", int'(err_offset), 0);
    reset = 1'b1;
    repeat (2) @(posedge clock); #1;
    check("midrst_no_more_bytes", int'(out_valid), 0);

    // Write pointer wrap
    do_reset();
    for (int i = 0; i < HS - 2; i++) send_tok(1'b0, 8'($urandom), 0, 0);
    send_tok(1'b1, 8'h00, 2, 5);
    send_tok(1'b1, 8'h00, 4000, 18);
    drain();
    check("wrap_wr_ptr", int'(hb_wr_addr), gptr);

    // Random tokens under random backpressure
    ready_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) send_tok(1'b0, 8'($urandom), 0, 0);
      else send_tok(1'b1, 8'h00, $urandom_range(1, HS - 1), $urandom_range(1, 18));
    end
    drain();
    ready_rand = 1'b0;
    check("random_wr_ptr", int'(hb_wr_addr), gptr);
    check("random_err", int'(err_offset), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
